hazard_fwd_unit: RTL
====================

Name: hazard_fwd_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipelined datapath. It holds a shadow scoreboard of the in-flight instructions after ID and drives the following:
- forwarding selects for the EX-stage operand muxes;
- the load-use stall for PC and IF/ID, with bubble injection into ID/EX;
- the wrong-path flush on a taken branch or jump.
It also keeps saturating stall and flush counters for performance measurement.

Parameters:
REG_AW, 5, register address width.
DEPTH, 3, number of scoreboard entries: entry0=EX, entry1=MEM, entry2=WB. Must be ≥3.
BR_STAGE, 1, scoreboard index of the stage that raises redirect (1 = MEM). Range 0..DEPTH-1.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  ID source register A
id_rt  in  REG_AW  ID source register B
id_uses_rt  in  1  ID instruction reads rt as an operand
id_rd  in  REG_AW  ID destination, after RegDst selection
id_regwrite  in  1  ID instruction writes the register file
id_memread  in  1  ID instruction is a load
redirect  in  1  branch taken or jump resolved at stage BR_STAGE
cnt_clr  in  1  synchronous clear of both counters
stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
flush  out  1  zero IF/ID and all pipeline registers older than ID up to BR_STAGE
fwd_a  out  2  EX operand A source
fwd_b  out  2  EX operand B source
stall_cnt  out  CNT_W  cycles with stall=1, saturating
flush_cnt  out  CNT_W  cycles with flush=1, saturating

Behaviour:
- Scoreboard entry fields: {valid, rs, rt, uses_rt, rd, regwrite, memread}.
- Shift on every clock edge:
  - entry[i] <= entry[i-1] for i ≥ 1.
  - entry0 <= ID fields with valid = id_valid & ~stall & ~flush.
  - Otherwise entry0 loads a bubble (valid=0).
- Redirect kill: when redirect=1, entries 0..BR_STAGE-1 are wrong path. Their shifted copies (new entries 1..BR_STAGE) load valid=0.
- flush = redirect. Combinational, same cycle, no latency.
- stall is combinational:
  - stall = id_valid & e0.valid & e0.memread & e0.rd≠0 & (e0.rd==id_rs | (id_uses_rt & e0.rd==id_rt)) & ~redirect.
  - Redirect has priority over stall.
  - Each load-use pair stalls exactly 1 cycle.
- Forwarding is combinational, evaluated for entry0 (the instruction in EX):
  - fwd_a = 01 (MEM) if e1.valid & e1.regwrite & e1.rd≠0 & e1.rd==e0.rs.
  - Else fwd_a = 10 (WB) under the same test on e2.
  - Else fwd_a = 00 (register file).
  - fwd_b uses the same rules on e0.rt and additionally requires e0.uses_rt.
  - MEM has priority over WB.
  - If e0.valid=0, both selects are 00.
  - Register 0 is never forwarded.
- Counters:
  - Each increments by 1 per cycle its event is high.
  - Each holds at 2^CNT_W-1.
  - cnt_clr takes priority over increment and zeros both on the next edge.
- Reset (rst=1, at any time including mid-stall or mid-flush):
  - All entries go invalid immediately.
  - Counters go to 0.
  - stall=0, flush=0, fwd_a=fwd_b=00 while rst is high. Outputs are gated by rst.
- First cycle after reset release: scoreboard is empty, so no forwarding or stall is possible; only flush can be asserted.
- Simultaneous redirect and stall condition: flush=1, stall=0, flush_cnt increments, stall_cnt unchanged.
- id_valid=0: entry0 becomes a bubble; stall=0.

Decomposition:
- Package hazard_pkg holds:
  - constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - the scoreboard entry typedef;
  - the bubble constant (all-zero entry).
- One sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, q), instantiated twice.

Test Plan:
- add r3,r1,r2 followed immediately by sub r4,r3,r5 -> fwd_a=01 for 1 cycle while sub is in EX; fwd_b=00.
- add r3; nop; or r6,r5,r3 -> fwd_b=10 in or's EX cycle; fwd_a=00.
- lw r4,0(r1) followed by add r5,r4,r1 -> stall=1 exactly 1 cycle, stall_cnt=1; next cycle stall=0; add in EX sees fwd_a=10.
- addi r7 in entry0 with redirect=1, then consumer of r7 reaches EX -> flush=1 that cycle; killed r7 is never forwarded (fwd 00); flush_cnt=1.
- Load-use on r4 coincident with redirect=1 -> stall=0, flush=1, stall_cnt unchanged. Writer to r0 followed by reader of r0 -> fwd 00.
- CNT_W=2 with 5 consecutive stall cycles -> stall_cnt=3. Assert rst mid-sequence -> all outputs 0 asynchronously, counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard / forwarding controller.
//   FWD_*       : encodings of the EX operand mux selects
//   SB_AW       : register address width stored in a scoreboard entry
//                 (upper bound for the REG_AW parameter of the top)
//   sb_entry_t  : one in-flight instruction in the shadow scoreboard
//   SB_BUBBLE   : an empty entry
//   writes_reg  : true when an entry will write a given non-zero register
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Entries always carry 8-bit register numbers; narrower addresses are
  // zero-extended on entry, which keeps equality compares exact.
  localparam int SB_AW = 8;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] rs;
    logic [SB_AW-1:0] rt;
    logic             uses_rt;
    logic [SB_AW-1:0] rd;
    logic             regwrite;
    logic             memread;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // Register 0 is hard-wired, so a write to it never produces a value.
  function automatic logic writes_reg(input sb_entry_t e, input logic [SB_AW-1:0] r);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == r);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance measurement.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears q
//   clr : synchronous clear, wins over inc
//   inc : count one event this cycle
//   q   : current count, holds at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// A shadow scoreboard follows every instruction that left ID
// (entry0 = EX, entry1 = MEM, entry2 = WB, further entries are spare).
//   clk, rst                : clock (rising) and asynchronous active-high reset
//   id_*                    : decoded fields of the instruction sitting in ID
//   redirect                : taken branch / jump resolved at scoreboard index BR_STAGE
//   cnt_clr                 : synchronous clear of both performance counters
//   stall                   : hold PC and IF/ID, bubble into ID/EX (load-use)
//   flush                   : kill the wrong-path instructions (equals redirect)
//   fwd_a, fwd_b            : EX operand mux selects (see hazard_pkg FWD_*)
//   stall_cnt, flush_cnt    : saturating counts of stall / flush cycles
// All outputs are forced to zero while rst is high.
module hazard_fwd_unit #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int BR_STAGE = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              redirect,
  input  logic              cnt_clr,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  import hazard_pkg::*;

  sb_entry_t sb      [DEPTH];
  sb_entry_t sb_next [DEPTH];
  sb_entry_t id_entry;
  logic      load_use;

  // ID instruction in scoreboard form; valid is decided when it is shifted in.
  always_comb begin
    id_entry          = SB_BUBBLE;
    id_entry.valid    = id_valid;
    id_entry.rs       = SB_AW'(id_rs);
    id_entry.rt       = SB_AW'(id_rt);
    id_entry.uses_rt  = id_uses_rt;
    id_entry.rd       = SB_AW'(id_rd);
    id_entry.regwrite = id_regwrite;
    id_entry.memread  = id_memread;
  end

  // A load in EX whose result the ID instruction needs cannot be forwarded
  // in time: the consumer waits one cycle, by which time the load is in MEM
  // and its data reaches EX through the WB forwarding path.
  always_comb begin
    load_use = id_valid && sb[0].valid && sb[0].memread && (sb[0].rd != '0) &&
               ((sb[0].rd == id_entry.rs) ||
                (id_uses_rt && (sb[0].rd == id_entry.rt)));
  end

  // Redirect outranks the load-use stall: the consumer is on the wrong path.
  assign flush = !rst && redirect;
  assign stall = !rst && load_use && !redirect;

  // Shift the scoreboard one stage. Instructions younger than the redirecting
  // stage (entries 0..BR_STAGE-1) are wrong path, so their shifted copies die.
  always_comb begin
    sb_next[0]       = id_entry;
    sb_next[0].valid = id_valid && !stall && !flush;
    for (int i = 1; i < DEPTH; i++) begin
      sb_next[i] = sb[i-1];
      if (redirect && (i <= BR_STAGE)) begin
        sb_next[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb[i] <= SB_BUBBLE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        sb[i] <= sb_next[i];
      end
    end
  end

  // Forwarding for the instruction in EX; MEM holds the younger value and wins.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst && sb[0].valid) begin
      if (writes_reg(sb[1], sb[0].rs)) begin
        fwd_a = FWD_MEM;
      end else if (writes_reg(sb[2], sb[0].rs)) begin
        fwd_a = FWD_WB;
      end
      if (sb[0].uses_rt) begin
        if (writes_reg(sb[1], sb[0].rt)) begin
          fwd_b = FWD_MEM;
        end else if (writes_reg(sb[2], sb[0].rt)) begin
          fwd_b = FWD_WB;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (stall),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (flush),
    .q   (flush_cnt)
  );

endmodule
